fp_add_scheduler: RTL and testbench

Round-robin scheduler that shares one pipelined single-precision floating-point adder (the adder wrapper with registered output) among N requesters in the Kalman filter datapath. It accepts one add request per cycle, drives the adder operands and valid, and carries a requester tag alongside the adder pipeline. It returns each sum to the requester that issued it, with a fixed, known latency.

---
 rtl/fp_add_scheduler.sv | 123 ++++++++++++
 tb/tb_fp_add_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_scheduler
// Description : Round-robin sharing of one pipelined FP adder among N
//               requesters; a tag pipeline routes each sum back to its issuer.
// Revision    : 1.0  initial release
// ============================================================================
module fp_add_scheduler #(
    parameter int N       = 4,
    parameter int DATA_W  = 32,
    parameter int ADD_LAT = 12
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N-1:0]                   req,
    input  logic [N*DATA_W-1:0]            req_a,
    input  logic [N*DATA_W-1:0]            req_b,
    output logic [N-1:0]                   grant,
    output logic [DATA_W-1:0]              add_a,
    output logic [DATA_W-1:0]              add_b,
    output logic                           add_valid,
    input  logic [DATA_W-1:0]              add_result,
    output logic [N-1:0]                   rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
    output logic [$clog2(ADD_LAT+2)-1:0]   inflight
);

    localparam int c_PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int c_CNT_W = $clog2(ADD_LAT + 2);

    logic [c_PTR_W-1:0] r_ptr;
    logic [N-1:0]       r_issue_tag;
    logic [ADD_LAT-1:0] r_vld_pipe;
    logic [N-1:0]       r_tag_pipe [ADD_LAT];
    logic [c_CNT_W-1:0] r_inflight;

    logic [N-1:0]       w_grant;
    logic               w_found;
    logic [c_PTR_W-1:0] w_win;
    logic [c_PTR_W-1:0] w_next_ptr;
    logic [DATA_W-1:0]  w_sel_a;
    logic [DATA_W-1:0]  w_sel_b;

    // Scan requesters starting at the pointer; the first asserted one wins.
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = '0;
        w_found = 1'b0;
        w_win   = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_found && req[idx]) begin
                w_found      = 1'b1;
                w_grant[idx] = 1'b1;
                w_win        = c_PTR_W'(idx);
                w_sel_a      = req_a[idx*DATA_W +: DATA_W];
                w_sel_b      = req_b[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign w_next_ptr = (w_win == c_PTR_W'(N - 1)) ? '0 : w_win + c_PTR_W'(1);
    assign grant      = w_grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr       <= '0;
            add_valid   <= 1'b0;
            add_a       <= '0;
            add_b       <= '0;
            r_issue_tag <= '0;
        end else begin
            add_valid   <= w_found;
            r_issue_tag <= w_grant;
            if (w_found) begin
                r_ptr <= w_next_ptr;
                add_a <= w_sel_a;
                add_b <= w_sel_b;
            end
        end
    end

    // Tag pipeline mirrors the adder latency so the tag exits with its sum.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                r_tag_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe    <= {r_vld_pipe[ADD_LAT-2:0], add_valid};
            r_tag_pipe[0] <= r_issue_tag;
            for (int i = 1; i < ADD_LAT; i++) begin
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
        end
    end

    assign rsp_valid = r_vld_pipe[ADD_LAT-1] ? r_tag_pipe[ADD_LAT-1] : '0;
    assign rsp_data  = add_result;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            case ({add_valid, |rsp_valid})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign inflight = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_scheduler
// Description : Randomized bench for fp_add_scheduler with a scoreboard model
//               and a behavioural pipelined adder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fp_add_scheduler;

    localparam int c_N       = 4;
    localparam int c_DATA_W  = 32;
    localparam int c_ADD_LAT = 12;
    localparam int c_CNT_W   = $clog2(c_ADD_LAT + 2);

    logic                      clock;
    logic                      reset;
    logic [c_N-1:0]            req;
    logic [c_N*c_DATA_W-1:0]   req_a;
    logic [c_N*c_DATA_W-1:0]   req_b;
    logic [c_N-1:0]            grant;
    logic [c_DATA_W-1:0]       add_a;
    logic [c_DATA_W-1:0]       add_b;
    logic                      add_valid;
    logic [c_DATA_W-1:0]       add_result;
    logic [c_N-1:0]            rsp_valid;
    logic [c_DATA_W-1:0]       rsp_data;
    logic [c_CNT_W-1:0]        inflight;

    fp_add_scheduler #(.N(c_N), .DATA_W(c_DATA_W), .ADD_LAT(c_ADD_LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .grant      (grant),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_valid  (add_valid),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .inflight   (inflight)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Floating-point helpers, exact for integer-valued operands below 2^24.
    function automatic real f2real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2f(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] i2f(input int n);
        int          p;
        logic [31:0] m;
        if (n == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 24; i++) if (n[i]) p = i;
        m = 32'(n) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // Behavioural adder with registered output, ADD_LAT cycles deep.
    logic [31:0] r_apipe [c_ADD_LAT];
    always @(posedge clock) begin
        r_apipe[0] <= real2f(f2real(add_a) + f2real(add_b));
        for (int i = 1; i < c_ADD_LAT; i++) r_apipe[i] <= r_apipe[i-1];
    end
    assign add_result = r_apipe[c_ADD_LAT-1];

    typedef struct {
        int          due;
        int          who;
        logic [31:0] sum;
    } rsp_t;

    rsp_t        m_q[$];
    int          m_ptr;
    int          m_cycle;
    logic        m_prev_acc;
    logic [31:0] m_last_a;
    logic [31:0] m_last_b;
    int          m_ia [c_N];
    int          m_ib [c_N];

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, m_cycle, obs, exp);
    endtask

    // One clock cycle: drive, check mid-cycle, then advance the model.
    task automatic cycle(input logic rst_v, input logic [c_N-1:0] r, input logic rnd_ops);
        int          win;
        int          infl;
        logic [c_N-1:0] eg;
        reset = rst_v;
        req   = r;
        if (rnd_ops) begin
            for (int i = 0; i < c_N; i++) begin
                m_ia[i] = int'($urandom_range(0, 4095));
                m_ib[i] = int'($urandom_range(0, 4095));
            end
        end
        for (int i = 0; i < c_N; i++) begin
            req_a[i*c_DATA_W +: c_DATA_W] = i2f(m_ia[i]);
            req_b[i*c_DATA_W +: c_DATA_W] = i2f(m_ib[i]);
        end
        #4;
        win = -1;
        for (int k = 0; k < c_N; k++) begin
            if (win < 0 && r[(m_ptr + k) % c_N]) win = (m_ptr + k) % c_N;
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        if (!rst_v) begin
            infl = 0;
            foreach (m_q[j]) if (m_q[j].due <= m_cycle + c_ADD_LAT - 1) infl++;
            check("grant", 64'(grant), 64'(eg));
            check("add_valid", 64'(add_valid), 64'(m_prev_acc));
            check("add_a", 64'(add_a), 64'(m_last_a));
            check("add_b", 64'(add_b), 64'(m_last_b));
            check("inflight", 64'(inflight), 64'(infl));
            if (m_q.size() > 0 && m_q[0].due == m_cycle) begin
                check("rsp_valid", 64'(rsp_valid), 64'(1) << m_q[0].who);
                check("rsp_data", 64'(rsp_data), 64'(m_q[0].sum));
            end else begin
                check("rsp_valid", 64'(rsp_valid), 64'(0));
            end
        end
        @(posedge clock);
        #1;
        if (rst_v) begin
            m_q.delete();
            m_ptr      = 0;
            m_prev_acc = 1'b0;
            m_last_a   = '0;
            m_last_b   = '0;
        end else begin
            if (m_q.size() > 0 && m_q[0].due == m_cycle) void'(m_q.pop_front());
            m_prev_acc = (win >= 0);
            if (win >= 0) begin
                m_q.push_back('{due: m_cycle + 1 + c_ADD_LAT, who: win,
                                sum: i2f(m_ia[win] + m_ib[win])});
                m_last_a = i2f(m_ia[win]);
                m_last_b = i2f(m_ib[win]);
                m_ptr    = (win + 1) % c_N;
            end
        end
        m_cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        m_cycle    = 0;
        m_ptr      = 0;
        m_prev_acc = 1'b0;
        m_last_a   = '0;
        m_last_b   = '0;
        for (int i = 0; i < c_N; i++) begin
            m_ia[i] = 0;
            m_ib[i] = 0;
        end
        reset = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;
        @(posedge clock);
        #1;
        cycle(1'b1, '0, 1'b0);
        cycle(1'b1, '0, 1'b0);
        idle(2);

        // Single op: 1.0 + 2.0 from requester 0.
        m_ia[0] = 1;
        m_ib[0] = 2;
        cycle(1'b0, 4'b0001, 1'b0);
        idle(16);

        // Full contention from reset.
        cycle(1'b1, '0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'b1111, 1'b1);
        idle(15);

        // Pointer skip: grant 1, then hold 0 and 2.
        cycle(1'b0, 4'b0010, 1'b1);
        cycle(1'b0, 4'b0101, 1'b1);
        cycle(1'b0, 4'b0101, 1'b0);
        idle(15);

        // Saturation on requester 1.
        for (int i = 0; i < 30; i++) cycle(1'b0, 4'b0010, 1'b1);
        idle(15);

        // Reset mid-flight: five ops, reset four cycles after the last.
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'(1 << (i % c_N)), 1'b1);
        idle(3);
        cycle(1'b1, '0, 1'b0);
        idle(16);
        cycle(1'b0, 4'b0100, 1'b1);
        idle(15);

        // Idle: outputs quiet, operands held.
        idle(20);

        // Random traffic.
        for (int i = 0; i < 300; i++) cycle(1'b0, 4'($urandom_range(0, 15)), 1'b1);
        idle(15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
